// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the pipeline MEM
// stage (core) and an external program/data loader.
//
// Arbitration: the core has priority. A loader that has been denied for
// STARVE_MAX consecutive request cycles is forced through. When the loader
// is granted with l_lock set, it takes exclusive access for up to MAX_BURST
// grants, or until l_lock drops.
//
// Ports:
//   clk, reset        clock (rising edge), async active-low reset
//   c_*               core request/grant/read-return channel
//   l_*               loader request/grant/read-return channel (+ l_lock)
//   mem_*             single-port memory interface (read data 1 cycle late)
//   core_stall        c_req & !c_gnt, used to freeze the pipeline
//   stall_cnt         saturating core stall cycle counter
//
// Build option: define ARB_STATS_EN to enable stall_cnt. When it is not
// defined, stall_cnt is tied to zero.
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_BURST  = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    input  logic          l_lock,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          core_stall,
    output logic [15:0]   stall_cnt
);

    typedef enum logic {S_SHARE, S_BURST} stateT;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
    localparam logic [7:0] BURST_LIM  = 8'(MAX_BURST);

    stateT      state;
    logic [7:0] starveCnt;
    logic [7:0] burstCnt;
    logic [7:0] burstNext;
    logic       rvC;
    logic       rvL;

    // Grants are combinational; both are forced low while reset is held.
    always_comb begin
        c_gnt = 1'b0;
        l_gnt = 1'b0;
        if (reset) begin
            if (state == S_BURST)
                l_gnt = l_req;
            else if (starveCnt == STARVE_LIM && l_req)
                l_gnt = 1'b1;
            else if (c_req)
                c_gnt = 1'b1;
            else if (l_req)
                l_gnt = 1'b1;
        end
    end

    // Memory mux: idle bus drives zeros.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (c_gnt) begin
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
        end else if (l_gnt) begin
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
        end
    end

    assign mem_we     = (c_gnt & c_we) | (l_gnt & l_we);
    assign core_stall = c_req & ~c_gnt;

    // Burst count including this cycle's grant; the exit check uses this so
    // the MAX_BURST-th grant is still issued before dropping back to sharing.
    assign burstNext = burstCnt + {7'd0, l_gnt};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_SHARE;
            starveCnt <= '0;
            burstCnt  <= '0;
            rvC       <= 1'b0;
            rvL       <= 1'b0;
        end else begin
            rvC <= c_gnt & ~c_we;
            rvL <= l_gnt & ~l_we;

            if (l_gnt || !l_req)
                starveCnt <= '0;
            else if (starveCnt != STARVE_LIM)
                starveCnt <= starveCnt + 8'd1;

            case (state)
                S_SHARE: begin
                    if (l_gnt && l_lock) begin
                        state    <= S_BURST;
                        burstCnt <= 8'd1;
                    end
                end
                S_BURST: begin
                    // starveCnt is already cleared here: in a burst the
                    // loader is either granted or not requesting.
                    if (!l_lock || burstNext == BURST_LIM) begin
                        state    <= S_SHARE;
                        burstCnt <= '0;
                    end else begin
                        burstCnt <= burstNext;
                    end
                end
                default: begin
                    state    <= S_SHARE;
                    burstCnt <= '0;
                end
            endcase
        end
    end

    assign c_rvalid = rvC;
    assign l_rvalid = rvL;
    assign c_rdata  = mem_rdata;
    assign l_rdata  = mem_rdata;

`ifdef ARB_STATS_EN
    logic [15:0] stallCnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stallCnt <= '0;
        else if (core_stall && stallCnt != 16'hFFFF)
            stallCnt <= stallCnt + 16'd1;
    end

    assign stall_cnt = stallCnt;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a driver issues requests and pushes the
// expected per-cycle response; a negedge monitor pops and compares. A small
// synchronous RAM model backs mem_rdata, and a reference copy of its contents
// predicts the read data returned to each requester.
module tb_dmem_arbiter;
    localparam int AW = 32, DW = 32, MAXB = 8, STV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          c_req, c_we, c_gnt, c_rvalid;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;
    logic          l_req, l_we, l_lock, l_gnt, l_rvalid;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata, l_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          core_stall;
    logic [15:0]   stall_cnt;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB), .STARVE_MAX(STV)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .core_stall(core_stall), .stall_cnt(stall_cnt)
    );

    // Environment RAM: 16 words, read-before-write, data one cycle late.
    logic          ramClr;
    logic [DW-1:0] ram [16];
    always @(posedge clk) begin
        if (ramClr) begin
            for (int i = 0; i < 16; i++) ram[i] <= 32'h1000 + 32'(i);
        end else if (mem_we) begin
            ram[mem_addr[3:0]] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr[3:0]];
    end

`ifdef ARB_STATS_EN
    localparam logic [15:0] EXP_STALLS5 = 16'd5;
`else
    localparam logic [15:0] EXP_STALLS5 = 16'd0;
`endif

    typedef struct {
        bit cr, cwe, lr, lwe, lk;
        logic [31:0] ca, cwd, la, lwd;
    } drvT;

    typedef struct {
        bit cg, lg, we, stall, crv, lrv;
        logic [31:0] addr, wdata;
        logic [15:0] scnt;
    } expT;

    typedef struct {
        bit core;
        logic [31:0] data;
    } rdT;

    expT expQ[$];
    rdT  rdQ[$];
    drvT d;
    bit  rstN;

    // Reference model state, expressed as the rules talk about it.
    bit          inBurst;
    int          burstGrants, starved, stalls;
    bit          pendRdC, pendRdL, lastCg, lastLg;
    logic [31:0] refMem [16];

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic setIdle();
        d = '{default: 0};
    endtask

    // One clock cycle: apply stimulus after the edge, predict the response.
    task automatic step();
        expT e;
        rdT  r;
        bit  cg, lg;
        @(posedge clk);
        #1;
        reset = rstN;
        c_req = d.cr; c_we = d.cwe; c_addr = d.ca; c_wdata = d.cwd;
        l_req = d.lr; l_we = d.lwe; l_addr = d.la; l_wdata = d.lwd; l_lock = d.lk;
        if (!rstN) begin
            inBurst = 0; burstGrants = 0; starved = 0; stalls = 0;
            pendRdC = 0; pendRdL = 0;
            rdQ.delete();
        end
        cg = 0; lg = 0;
        if (rstN) begin
            if (inBurst) lg = d.lr;
            else if (starved == STV && d.lr) lg = 1;
            else if (d.cr) cg = 1;
            else if (d.lr) lg = 1;
        end
        e.cg    = cg;
        e.lg    = lg;
        e.we    = (cg & d.cwe) | (lg & d.lwe);
        e.addr  = cg ? d.ca  : (lg ? d.la  : 32'h0);
        e.wdata = cg ? d.cwd : (lg ? d.lwd : 32'h0);
        e.stall = d.cr & !cg;
        e.crv   = pendRdC;
        e.lrv   = pendRdL;
`ifdef ARB_STATS_EN
        e.scnt  = 16'(stalls);
`else
        e.scnt  = 16'h0;
`endif
        expQ.push_back(e);
        lastCg = cg; lastLg = lg;
        if (rstN) begin
            if (cg && !d.cwe) begin r.core = 1; r.data = refMem[d.ca[3:0]]; rdQ.push_back(r); end
            if (lg && !d.lwe) begin r.core = 0; r.data = refMem[d.la[3:0]]; rdQ.push_back(r); end
            if (e.we) refMem[e.addr[3:0]] = e.wdata;
            pendRdC = cg && !d.cwe;
            pendRdL = lg && !d.lwe;
            if (e.stall && stalls < 65535) stalls++;
            if (lg || !d.lr) starved = 0;
            else if (starved < STV) starved++;
            if (inBurst) begin
                if (lg) burstGrants++;
                if (!d.lk || burstGrants == MAXB) begin inBurst = 0; burstGrants = 0; end
            end else if (lg && d.lk) begin
                inBurst = 1; burstGrants = 1;
            end
        end
    endtask

    // Monitor: one expected entry per cycle, read data when a return is due.
    expT mE;
    rdT  mR;
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            mE = expQ.pop_front();
            chk("c_gnt", 64'(c_gnt), 64'(mE.cg));
            chk("l_gnt", 64'(l_gnt), 64'(mE.lg));
            chk("mem_we", 64'(mem_we), 64'(mE.we));
            chk("mem_addr", 64'(mem_addr), 64'(mE.addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(mE.wdata));
            chk("core_stall", 64'(core_stall), 64'(mE.stall));
            chk("c_rvalid", 64'(c_rvalid), 64'(mE.crv));
            chk("l_rvalid", 64'(l_rvalid), 64'(mE.lrv));
            chk("stall_cnt", 64'(stall_cnt), 64'(mE.scnt));
            if (mE.crv || mE.lrv) begin
                if (rdQ.size() == 0) begin
                    chk("rd_queue_empty", 64'(1), 64'(0));
                end else begin
                    mR = rdQ.pop_front();
                    if (mR.core) chk("c_rdata", 64'(c_rdata), 64'(mR.data));
                    else         chk("l_rdata", 64'(l_rdata), 64'(mR.data));
                end
            end
        end
    end

    logic [5:0]  lv6, sv6;
    logic [12:0] lv13, cv13, sv13;

    initial begin
        for (int i = 0; i < 16; i++) refMem[i] = 32'h1000 + 32'(i);
        ramClr = 1'b1;
        reset = 1'b0;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0; l_lock = 0;
        rstN = 0;
        setIdle();
        step();
        ramClr = 1'b0;
        // Requests under reset must not be granted.
        d.cr = 1; d.lr = 1;
        step(); #1;
        chk("rst_c_gnt", 64'(c_gnt), 64'(0));
        chk("rst_l_gnt", 64'(l_gnt), 64'(0));
        chk("rst_c_rvalid", 64'(c_rvalid), 64'(0));
        rstN = 1;
        setIdle();
        step();

        // Core read of 0x10 with loader idle.
        d.cr = 1; d.ca = 32'h10;
        step(); #1;
        chk("t1_c_gnt", 64'(c_gnt), 64'(1));
        chk("t1_mem_addr", 64'(mem_addr), 64'h10);
        setIdle();
        step(); #1;
        chk("t1_c_rvalid", 64'(c_rvalid), 64'(1));
        chk("t1_c_rdata", 64'(c_rdata), 64'h1000);
        chk("t1_l_rvalid", 64'(l_rvalid), 64'(0));

        // Starvation: loader forced on the 5th contended cycle.
        step();
        d.cr = 1; d.ca = 32'h4; d.lr = 1; d.la = 32'h8;
        for (int i = 0; i < 6; i++) begin
            step(); #1;
            lv6[i] = l_gnt; sv6[i] = core_stall;
        end
        chk("t2_l_gnt_seq", 64'(lv6), 64'(6'b010000));
        chk("t2_stall_seq", 64'(sv6), 64'(6'b010000));
        setIdle();
        step();

        // Locked burst: 4 core wins, 8 locked loader writes, core again.
        d.cr = 1; d.ca = 32'h2; d.lr = 1; d.lk = 1; d.lwe = 1; d.la = 32'h5; d.lwd = 32'hA5A5_0005;
        for (int i = 0; i < 13; i++) begin
            step(); #1;
            lv13[i] = l_gnt; cv13[i] = c_gnt; sv13[i] = core_stall;
        end
        chk("t3_l_gnt_seq", 64'(lv13), 64'(13'h0FF0));
        chk("t3_c_gnt_seq", 64'(cv13), 64'(13'h100F));
        chk("t3_stall_seq", 64'(sv13), 64'(13'h0FF0));
        setIdle();
        step();

        // Loader write with core idle.
        d.lr = 1; d.lwe = 1; d.la = 32'h40; d.lwd = 32'hDEADBEEF;
        step(); #1;
        chk("t4_mem_we", 64'(mem_we), 64'(1));
        chk("t4_mem_addr", 64'(mem_addr), 64'h40);
        chk("t4_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        setIdle();
        step(); #1;
        chk("t4_l_rvalid", 64'(l_rvalid), 64'(0));

        // Reset in the middle of a locked read burst.
        d.lr = 1; d.lk = 1; d.la = 32'h3;
        repeat (3) step();
        rstN = 0;
        step(); #1;
        chk("t5_l_gnt_rst", 64'(l_gnt), 64'(0));
        chk("t5_l_rvalid_rst", 64'(l_rvalid), 64'(0));
        step();
        rstN = 1;
        d.cr = 1; d.ca = 32'h7;
        step(); #1;
        chk("t5_c_gnt_after", 64'(c_gnt), 64'(1));
        chk("t5_l_gnt_after", 64'(l_gnt), 64'(0));

        // Five stall cycles after a fresh reset.
        rstN = 0; setIdle();
        step();
        rstN = 1;
        d.cr = 1; d.lr = 1; d.lk = 1; d.la = 32'h9;
        repeat (9) step();
        setIdle();
        step(); #1;
        chk("t6_stall_cnt", 64'(stall_cnt), 64'(EXP_STALLS5));

        // Random traffic; pending requests stay stable until granted,
        // with an occasional withdrawal and an occasional reset.
        for (int n = 0; n < 3000; n++) begin
            if (!(d.cr && !lastCg) || $urandom_range(0, 15) == 0) begin
                d.cr  = $urandom_range(0, 9) < 6;
                d.cwe = 1'($urandom_range(0, 1));
                d.ca  = $urandom_range(0, 15);
                d.cwd = $urandom;
            end
            if (!(d.lr && !lastLg) || $urandom_range(0, 15) == 0) begin
                d.lr  = $urandom_range(0, 9) < 5;
                d.lwe = 1'($urandom_range(0, 1));
                d.la  = $urandom_range(0, 15);
                d.lwd = $urandom;
            end
            if ($urandom_range(0, 7) == 0) d.lk = 1'($urandom_range(0, 1));
            rstN = !($urandom_range(0, 499) == 0);
            step();
        end
        rstN = 1;
        setIdle();
        repeat (3) step();
        @(negedge clk); #1;
        chk("drain_expQ", 64'(expQ.size()), 64'(0));
        chk("drain_rdQ", 64'(rdQ.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (core requester) and an external program/data loader (loader requester).
- Arbitrates each cycle with core priority, bounded loader starvation and locked loader bursts.
- Drives the memory address, write data and write enable, and returns read data with valid one cycle later.
- Generates core_stall, which the hazard logic uses to freeze the pipeline.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_BURST, 8, maximum consecutive locked loader grants (range 2..255).
- STARVE_MAX, 4, consecutive denied loader-request cycles before loader is forced (range 1..255).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- c_req  in  1  core access request.
- c_we  in  1  core write (1) / read (0).
- c_addr  in  AW  core address.
- c_wdata  in  DW  core write data.
- c_gnt  out  1  core granted this cycle.
- c_rvalid  out  1  core read data valid.
- c_rdata  out  DW  core read data.
- l_req  in  1  loader request.
- l_we  in  1  loader write/read.
- l_addr  in  AW  loader address.
- l_wdata  in  DW  loader write data.
- l_lock  in  1  loader requests burst lock.
- l_gnt  out  1  loader granted this cycle.
- l_rvalid  out  1  loader read data valid.
- l_rdata  out  DW  loader read data.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid the cycle after the address is presented.
- core_stall  out  1  c_req & !c_gnt.
- stall_cnt  out  16  core stall cycle count (see Optional Feature).

Behaviour:
- States:
  - S_SHARE: grants are decided per cycle.
  - S_BURST: the loader holds exclusive access.
- Registers:
  - state.
  - starve_cnt, 8 bits.
  - burst_cnt, 8 bits.
  - rv_c, rv_l: read-valid flags.
- Reset (reset=0, asynchronous): state=S_SHARE, all counters=0, rv_c=rv_l=0. Resulting outputs: c_rvalid=0, l_rvalid=0, and all grants=0 while reset is held.
- Grants are combinational from the current state and requests. At most one grant per cycle; c_gnt & l_gnt is never 1.
- S_SHARE grant rule:
  - If starve_cnt==STARVE_MAX and l_req=1: l_gnt=1.
  - Else if c_req=1: c_gnt=1.
  - Else if l_req=1: l_gnt=1.
- starve_cnt:
  - Increments each cycle that l_req & !l_gnt.
  - Clears on any l_gnt or when l_req=0.
  - Saturates at STARVE_MAX.
- S_SHARE to S_BURST: l_gnt & l_lock. burst_cnt is set to 1.
- S_BURST:
  - l_gnt = l_req; c_gnt=0.
  - burst_cnt increments on each l_gnt.
  - Exit to S_SHARE when l_lock=0 at a clock edge or when burst_cnt==MAX_BURST (after that grant). burst_cnt clears on exit.
  - After a MAX_BURST exit, the core wins the next cycle if c_req=1, even if the loader is starved; starve_cnt is cleared on exit.
- Memory mux:
  - Granted requester's addr/wdata drive mem_addr/mem_wdata.
  - mem_we = (c_gnt & c_we) | (l_gnt & l_we).
  - With no grant, mem_addr=0, mem_wdata=0, mem_we=0.
- Read return:
  - rv_c <= c_gnt & !c_we; rv_l <= l_gnt & !l_we.
  - c_rvalid=rv_c, l_rvalid=rv_l.
  - c_rdata and l_rdata both mirror mem_rdata. Consumers qualify with their rvalid.
- Latency: grant is 0 cycles from request; read data arrives 1 cycle after grant.
- Back-to-back grants to alternating requesters are legal every cycle.
- core_stall is purely combinational: high whenever c_req=1 and the core is not granted (loader forced, or S_BURST).
- A requester must hold req/we/addr/wdata stable until granted. Dropping req before grant withdraws the request without side effect.
- Reset asserted mid-burst aborts the burst. No pending rvalid survives reset.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined: stall_cnt is a 16-bit counter.
  - Increments each cycle core_stall=1.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: no counter logic; stall_cnt is tied to 16'h0000.

Test Plan:
- Core read 0x10 and loader idle: c_gnt=1 in the same cycle, mem_addr=0x10. Next cycle c_rvalid=1 and c_rdata=mem_rdata. l_rvalid stays 0.
- Starvation: c_req=1 and l_req=1 held continuously, STARVE_MAX=4. Loader is denied 4 cycles, then l_gnt=1 on cycle 5 with core_stall=1. Core is granted again on cycle 6.
- Burst: l_lock=1 and l_req=1 for 12 cycles, MAX_BURST=8, c_req=1. Exactly 8 consecutive l_gnt, then c_gnt=1. core_stall=1 for those 8 cycles.
- Loader write 0xDEADBEEF to 0x40 with core idle: mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF. No rvalid follows.
- reset=0 driven asynchronously mid-burst after 3 grants: state returns to S_SHARE, rvalids=0. After release, c_req wins immediately.
- ARB_STATS_EN defined, 5 stall cycles: stall_cnt=5. Undefined: stall_cnt=0.
